// File: rtl/hbm_bench_scheduler.sv
// HBM benchmark sequencer: walks a port range, issues a fixed count of AXI burst commands per port, tracks outstanding/beat/OKAY counts.
// cmd_* is held while cmd_valid && !cmd_ready and issue stalls at MAX_OUTSTANDING; HBM_SCHED_TIMEOUT_EN adds a drain watchdog.
module hbm_bench_scheduler #(
    parameter int          MAX_OUTSTANDING = 16,
    parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468,
    parameter int          TIMEOUT_CYCLES  = 4096
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_cfg_mode,
    input  logic        i_cfg_random,
    input  logic [3:0]  i_cfg_len,
    input  logic [31:0] i_cfg_num_txn,
    input  logic [4:0]  i_cfg_port_first,
    input  logic [4:0]  i_cfg_port_last,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic        o_cmd_write,
    output logic [32:0] o_cmd_addr,
    output logic [3:0]  o_cmd_len,
    output logic [4:0]  o_select_port,
    input  logic        i_wnext,
    input  logic        i_bdone,
    input  logic        i_bokay,
    input  logic        i_rdone,
    input  logic        i_rokay,
    output logic [35:0] o_count_wnext,
    output logic [35:0] o_count_bokay,
    output logic [35:0] o_count_rokay,
    output logic        o_isread,
    output logic        o_iswrite,
    output logic [3:0]  o_state,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_SETUP = 4'd1;
    localparam logic [3:0] S_ISSUE = 4'd2;
    localparam logic [3:0] S_DRAIN = 4'd3;
    localparam logic [3:0] S_NEXT  = 4'd4;
    localparam logic [3:0] S_DONE  = 4'd5;

    localparam logic [6:0] MAX_OS = 7'(MAX_OUTSTANDING);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 64 || TIMEOUT_CYCLES < 1 || LFSR_SEED == 32'd0) begin : g_param_check
        $error("hbm_bench_scheduler: parameter out of range");
    end

    typedef struct packed {
        logic [1:0]  mode;
        logic        random;
        logic [3:0]  len;
        logic [31:0] num_txn;
        logic [4:0]  port_last;
    } cfg_t;

    cfg_t        r_cfg;
    logic [3:0]  r_state;
    logic [31:0] r_txn_cnt;
    logic [6:0]  r_outstanding;
    logic [27:0] r_offset;
    logic [4:0]  r_sel;
    logic [31:0] r_lfsr;
    logic        r_dir_wr;
    logic [35:0] r_cnt_wnext;
    logic [35:0] r_cnt_bokay;
    logic [35:0] r_cnt_rokay;
`ifdef HBM_SCHED_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_to_cnt;
    logic        r_timeout;
`endif

    logic        w_cmd_valid;
    logic        w_accept;
    logic        w_cmd_write;
    logic [6:0]  w_os_sum;
    logic [6:0]  w_os_dec;
    logic [6:0]  w_os_next;
    logic [31:0] w_lfsr_next;
    logic [27:0] w_seq_step;

    assign w_cmd_valid = (r_state == S_ISSUE) && (r_outstanding < MAX_OS) && (r_txn_cnt != r_cfg.num_txn);
    assign w_accept    = w_cmd_valid && i_cmd_ready;
    // Mode 11 is an unused encoding and behaves as write-only.
    assign w_cmd_write = (r_cfg.mode == 2'b01) ? 1'b0 : (r_cfg.mode == 2'b10) ? r_dir_wr : 1'b1;

    assign w_os_sum  = r_outstanding + 7'(w_accept);
    assign w_os_dec  = 7'(i_bdone) + 7'(i_rdone);
    assign w_os_next = (w_os_sum > w_os_dec) ? (w_os_sum - w_os_dec) : 7'd0;

    // Galois form of x^32 + x^22 + x^2 + x + 1.
    assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);
    assign w_seq_step  = 28'({1'b0, r_cfg.len, 5'b0} + 10'd32);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cfg         <= '0;
            r_state       <= S_IDLE;
            r_txn_cnt     <= 32'd0;
            r_outstanding <= 7'd0;
            r_offset      <= 28'd0;
            r_sel         <= 5'd0;
            r_lfsr        <= LFSR_SEED;
            r_dir_wr      <= 1'b1;
            r_cnt_wnext   <= 36'd0;
            r_cnt_bokay   <= 36'd0;
            r_cnt_rokay   <= 36'd0;
`ifdef HBM_SCHED_TIMEOUT_EN
            r_to_cnt      <= 32'd0;
            r_timeout     <= 1'b0;
`endif
        end else begin
            r_outstanding <= w_os_next;
            if (r_state != S_DONE) begin
                if (i_wnext && r_cnt_wnext != '1)            r_cnt_wnext <= r_cnt_wnext + 36'd1;
                if (i_bdone && i_bokay && r_cnt_bokay != '1) r_cnt_bokay <= r_cnt_bokay + 36'd1;
                if (i_rdone && i_rokay && r_cnt_rokay != '1) r_cnt_rokay <= r_cnt_rokay + 36'd1;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_cfg       <= '{mode: i_cfg_mode, random: i_cfg_random, len: i_cfg_len,
                                         num_txn: i_cfg_num_txn, port_last: i_cfg_port_last};
                        r_cnt_wnext <= 36'd0;
                        r_cnt_bokay <= 36'd0;
                        r_cnt_rokay <= 36'd0;
                        r_offset    <= 28'd0;
                        r_sel       <= i_cfg_port_first;
                        r_dir_wr    <= 1'b1;
                        r_state     <= S_SETUP;
`ifdef HBM_SCHED_TIMEOUT_EN
                        r_timeout   <= 1'b0;
`endif
                    end
                end
                S_SETUP: begin
                    r_txn_cnt <= 32'd0;
                    r_offset  <= 28'd0;
                    r_state   <= (r_cfg.num_txn == 32'd0) ? S_NEXT : S_ISSUE;
                end
                S_ISSUE: begin
                    if (w_accept) begin
                        r_txn_cnt <= r_txn_cnt + 32'd1;
                        if (r_cfg.random) begin
                            r_lfsr   <= w_lfsr_next;
                            r_offset <= {w_lfsr_next[27:9], 9'b0};
                        end else begin
                            r_offset <= r_offset + w_seq_step;
                        end
                        if (r_cfg.mode == 2'b10) r_dir_wr <= ~r_dir_wr;
                        if (r_txn_cnt + 32'd1 == r_cfg.num_txn) begin
                            r_state  <= S_DRAIN;
`ifdef HBM_SCHED_TIMEOUT_EN
                            r_to_cnt <= 32'd0;
`endif
                        end
                    end
                end
                S_DRAIN: begin
`ifdef HBM_SCHED_TIMEOUT_EN
                    r_to_cnt <= r_to_cnt + 32'd1;
                    if (r_outstanding == 7'd0) begin
                        r_state <= S_NEXT;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_timeout     <= 1'b1;
                        r_outstanding <= 7'd0;
                        r_state       <= S_DONE;
                    end
`else
                    if (r_outstanding == 7'd0) r_state <= S_NEXT;
`endif
                end
                S_NEXT: begin
                    if (r_sel == r_cfg.port_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_sel   <= r_sel + 5'd1;
                        r_state <= S_SETUP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_valid   = w_cmd_valid;
    assign o_cmd_write   = w_cmd_write;
    assign o_cmd_addr    = {r_sel, r_offset};
    assign o_cmd_len     = r_cfg.len;
    assign o_select_port = r_sel;
    assign o_count_wnext = r_cnt_wnext;
    assign o_count_bokay = r_cnt_bokay;
    assign o_count_rokay = r_cnt_rokay;
    assign o_iswrite     = (r_state == S_ISSUE) && w_cmd_write;
    assign o_isread      = (r_state == S_ISSUE) && !w_cmd_write;
    assign o_state       = r_state;
    assign o_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done        = (r_state == S_DONE);
`ifdef HBM_SCHED_TIMEOUT_EN
    assign o_timeout     = r_timeout;
`else
    assign o_timeout     = 1'b0;
`endif

endmodule

// File: doc/hbm_bench_scheduler.md
Name: hbm_bench_scheduler

Overview:
Sequences the HBM benchmark traffic generator. Walks a configured range of pseudo-channel ports and issues a fixed number of AXI burst commands per port: write-only, read-only or alternating, at sequential or LFSR-random addresses. Caps outstanding transactions and counts write beats and OKAY responses. Drives the benchmark monitor signals (select_port, state, isread/iswrite, counters).

Parameters:
MAX_OUTSTANDING, 16, max issued-but-uncompleted commands (1..64)
LFSR_SEED, 32'hACE1_2468, random-address LFSR reset value (nonzero)
TIMEOUT_CYCLES, 4096, drain watchdog limit (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  pulse; begins a run when in IDLE or DONE
cfg_mode  in  2  00 write-only, 01 read-only, 10 alternate W/R (W first), 11 treated as 00
cfg_random  in  1  1 = LFSR addresses, 0 = sequential
cfg_len  in  4  AXI burst length minus 1 (beats = cfg_len+1)
cfg_num_txn  in  32  commands per port; 0 = skip port
cfg_port_first  in  5  first port
cfg_port_last  in  5  last port (inclusive)
cmd_valid  out  1  command valid
cmd_ready  in  1  generator accepts command
cmd_write  out  1  1 write, 0 read
cmd_addr  out  33  byte address
cmd_len  out  4  burst length field
select_port  out  5  current port
wnext  in  1  one write beat accepted
bdone  in  1  write response handshake (any resp)
bokay  in  1  with bdone, resp == OKAY
rdone  in  1  read last-beat handshake
rokay  in  1  with rdone, resp == OKAY
count_wnext  out  36  write beats
count_bokay  out  36  OKAY write responses
count_rokay  out  36  OKAY read completions
isread  out  1  current command is a read
iswrite  out  1  current command is a write
state  out  4  FSM state encoding
busy  out  1  state != IDLE && state != DONE
done  out  1  high in DONE
timeout  out  1  watchdog fired

Behaviour:
- Reset, takes precedence over all other inputs: state=IDLE; cmd_valid=0; outstanding=0; all counters=0; select_port=0; cmd_addr=0; done=0; timeout=0; LFSR=LFSR_SEED; alternate toggle=write.
- Encoding: IDLE=0, SETUP=1, ISSUE=2, DRAIN=3, NEXT=4, DONE=5. Other codes go to IDLE on the next cycle.
- IDLE/DONE + start: latch all cfg_* into shadow registers. Clear the counters, timeout and the sequential offset. Set select_port=cfg_port_first. Go to SETUP. cfg_* changes mid-run are ignored.
- SETUP (1 cycle): txn_cnt=0, offset=0. If shadow num_txn==0, go to NEXT, else go to ISSUE.
- ISSUE: cmd_valid=1 when outstanding < MAX_OUTSTANDING. cmd_write, cmd_addr and cmd_len stay stable while valid && !ready.
- ISSUE, on valid&&ready: txn_cnt++ and outstanding++. Advance the address. In mode 10, toggle direction. When txn_cnt reaches num_txn, deassert valid the next cycle and go to DRAIN.
- Address: cmd_addr = {select_port, offset[27:0]}.
  - Sequential: offset += (len+1)*32, wrapping modulo 2^28.
  - Random: offset = {lfsr[27:9], 9'b0}. The 32-bit Galois LFSR (taps 32,22,2,1) steps once per accepted command.
- isread/iswrite reflect the direction of the pending/next command in ISSUE. Both are 0 elsewhere.
- outstanding decrements on each bdone or rdone. Same-cycle accept + completion nets 0. bdone and rdone in the same cycle decrement by 2. A decrement at 0 is ignored (no underflow).
- DRAIN: wait for outstanding==0, then go to NEXT.
- NEXT: if select_port==port_last, go to DONE; else select_port++ (wrapping 31->0) and go to SETUP. If port_first > port_last, the walk wraps through 31 to 0.
- Counters: count_wnext +1 per wnext, count_bokay +1 per bdone&&bokay, count_rokay +1 per rdone&&rokay. They are active in every non-reset state and saturate at 2^36-1.
- DONE: done=1 and counters hold until the next start.

Optional Feature:
Macro HBM_SCHED_TIMEOUT_EN.
- Defined: a cycle counter runs while in DRAIN and clears on entering DRAIN. If it reaches TIMEOUT_CYCLES, set timeout=1 (sticky until start or reset), force outstanding=0 and go to DONE.
- Undefined: no counter, timeout tied to 0, and DRAIN waits indefinitely.

Test Plan:
- Write-only, port 0..0, num_txn=4, len=7, sequential, cmd_ready=1, each command answered by 8 wnext and one bdone+bokay -> addrs 0x0,0x100,0x200,0x300; count_wnext=32; count_bokay=4; done=1.
- Alternate mode, ports 3..4, num_txn=2, len=0 -> per port W then R; addrs {3,0},{3,0x20},{4,0},{4,0x20}; select_port steps 3->4; final state=5.
- Backpressure: cmd_ready=0 for 10 cycles mid-ISSUE -> cmd_valid held, cmd_addr/cmd_write stable; txn_cnt unchanged.
- Outstanding cap: MAX_OUTSTANDING=2, no completions -> exactly 2 accepts, then cmd_valid=0. One bdone -> a single further accept.
- Random mode, seed default -> cmd_addr[8:0]==0 on every command; sequence matches the golden LFSR model; num_txn=0 on a port skips it with no commands.
- Reset asserted mid-ISSUE with outstanding=3 -> next cycle state=0, cmd_valid=0, counters=0. With HBM_SCHED_TIMEOUT_EN and no completions, DRAIN exits after 4096 cycles with timeout=1.
